// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings, oversampling
// constants and the 2-of-3 vote helper.
package uart_pkg;

    localparam int TICKS_PER_BIT = 16;
    localparam int MID_TICK      = 7;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous level; RESET_VAL sets the
// value both flops take in reset (1 for an idle-high serial line).
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: start, DATA_BITS data (LSB first), parity, stop.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling of every bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PAR_TYP   = 0,
    parameter int SB_TICK   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int                BW        = $clog2(DATA_BITS) + 1;
    localparam logic [BW-1:0]     LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic [3:0]        BIT_END   = 4'(TICKS_PER_BIT - 1);
    localparam logic [3:0]        STOP_END  = 4'(SB_TICK - 1);
    localparam logic              PAR_BIT   = (PAR_TYP != 0) ? PAR_ODD : PAR_EVEN;
`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0]        START_END = 4'(MID_TICK + 2);
`else
    localparam logic [3:0]        START_END = 4'(MID_TICK);
`endif

    rx_state_e            state;
    logic [3:0]           tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] sh;
    logic                 par_bit;
    logic                 rx_s;
    logic                 sample;
    logic [DATA_BITS:0]   sh_cat;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // The two votes are taken on the two ticks before each decision tick; the
    // decision tick supplies the third sample, so the window sits on mid-bit.
    logic [3:0] dec_tick;
    logic [1:0] vote;

    always_comb begin
        dec_tick = BIT_END;
        if (state == RX_START)
            dec_tick = START_END;
        else if (state == RX_STOP)
            dec_tick = STOP_END;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vote <= 2'b11;
        end else if (tick) begin
            if (tick_cnt == dec_tick - 4'd2)
                vote[0] <= rx_s;
            if (tick_cnt == dec_tick - 4'd1)
                vote[1] <= rx_s;
        end
    end

    assign sample = maj3(vote[0], vote[1], rx_s);
`else
    assign sample = rx_s;
`endif

    assign sh_cat = {sample, sh};

    // rx_done is a one-cycle valid strobe with no back-pressure; rx_data,
    // parity_err and frame_err are loaded with it and hold until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RX_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            sh         <= '0;
            par_bit    <= 1'b0;
            rx_data    <= '0;
            rx_done    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        state    <= RX_START;
                        tick_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end

                RX_START: begin
                    if (tick) begin
                        if (tick_cnt == START_END) begin
                            tick_cnt <= '0;
                            if (!sample) begin
                                state   <= RX_DATA;
                                bit_cnt <= '0;
                            end else begin
                                state <= RX_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end

                RX_DATA: begin
                    if (tick) begin
                        if (tick_cnt == BIT_END) begin
                            tick_cnt <= '0;
                            sh       <= sh_cat[DATA_BITS:1];
                            if (bit_cnt == LAST_BIT)
                                state <= RX_PARITY;
                            else
                                bit_cnt <= bit_cnt + 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end

                RX_PARITY: begin
                    if (tick) begin
                        if (tick_cnt == BIT_END) begin
                            tick_cnt <= '0;
                            par_bit  <= sample;
                            state    <= RX_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end

                RX_STOP: begin
                    if (tick) begin
                        if (tick_cnt == STOP_END) begin
                            // A low stop sample still delivers the frame; with
                            // the line held low IDLE restarts at once (break).
                            tick_cnt   <= '0;
                            state      <= RX_IDLE;
                            busy       <= 1'b0;
                            rx_done    <= 1'b1;
                            rx_data    <= sh;
                            parity_err <= par_bit ^ (^sh) ^ PAR_BIT;
                            frame_err  <= ~sample;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end

                default: begin
                    state    <= RX_IDLE;
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: even- and odd-parity instances share one serial line;
// table-driven frames plus hand-written glitch, break and reset sequences.
module tb_uart_rx;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       rx;

    logic [7:0] data_e, data_o;
    logic       done_e, done_o;
    logic       perr_e, perr_o;
    logic       ferr_e, ferr_o;
    logic       busy_e, busy_o;

    int n_pass  = 0;
    int n_total = 0;
    int cnt_e   = 0;
    int cnt_o   = 0;
    int base_e  = 0;
    int base_o  = 0;
    int tcnt    = 0;

`ifdef UART_RX_MAJORITY_EN
    localparam logic VOTING = 1'b1;
`else
    localparam logic VOTING = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       exp_perr_e;
        logic       exp_perr_o;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[7];

    uart_rx #(.DATA_BITS(8), .PAR_TYP(0), .SB_TICK(16)) dut_even (
        .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx),
        .rx_data(data_e), .rx_done(done_e), .parity_err(perr_e),
        .frame_err(ferr_e), .busy(busy_e)
    );

    uart_rx #(.DATA_BITS(8), .PAR_TYP(1), .SB_TICK(16)) dut_odd (
        .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx),
        .rx_data(data_o), .rx_done(done_o), .parity_err(perr_o),
        .frame_err(ferr_o), .busy(busy_o)
    );

    // clock / tick / reset-independent infrastructure
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tcnt = (tcnt == 3) ? 0 : tcnt + 1;
            tick = (tcnt == 3);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done_e) cnt_e = cnt_e + 1;
            if (done_o) cnt_o = cnt_o + 1;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard helpers
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total = n_total + 1;
        if (got === exp)
            n_pass = n_pass + 1;
        else
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic mark();
        base_e = cnt_e;
        base_o = cnt_o;
    endtask

    task automatic check_frame(input string tag, input int exp_n, input logic [7:0] exp_data,
                               input logic exp_pe, input logic exp_po, input logic exp_fe);
        check({tag, "_done_cnt_even"}, 32'(cnt_e - base_e), 32'(exp_n));
        check({tag, "_done_cnt_odd"},  32'(cnt_o - base_o), 32'(exp_n));
        check({tag, "_data_even"}, {24'd0, data_e}, {24'd0, exp_data});
        check({tag, "_data_odd"},  {24'd0, data_o}, {24'd0, exp_data});
        check({tag, "_perr_even"}, {31'd0, perr_e}, {31'd0, exp_pe});
        check({tag, "_perr_odd"},  {31'd0, perr_o}, {31'd0, exp_po});
        check({tag, "_ferr_even"}, {31'd0, ferr_e}, {31'd0, exp_fe});
        check({tag, "_ferr_odd"},  {31'd0, ferr_o}, {31'd0, exp_fe});
    endtask

    // driver tasks: the bench always leaves a wait just after a tick edge
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_bit(input logic val, input int glitch_tick);
        for (int t = 1; t <= 16; t++) begin
            rx = (t == glitch_tick) ? ~val : val;
            wait_ticks(1);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                              input int glitch_bit, input int glitch_tick);
        logic val;
        for (int b = 0; b < 11; b++) begin
            if (b == 0)      val = 1'b0;
            else if (b <= 8) val = data[b-1];
            else if (b == 9) val = par;
            else             val = stop;
            send_bit(val, (glitch_bit >= 0 && b == glitch_bit + 1) ? glitch_tick : 0);
        end
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h0F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        // reset state
        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data",  {24'd0, data_e}, 32'd0);
        check("rst_done",  {31'd0, done_e}, 32'd0);
        check("rst_perr",  {31'd0, perr_e}, 32'd0);
        check("rst_ferr",  {31'd0, ferr_e}, 32'd0);
        check("rst_busy",  {31'd0, busy_e}, 32'd0);
        rst_n = 1'b1;
        wait_ticks(2);
        check("idle_busy", {31'd0, busy_o}, 32'd0);

        // table: frames back to back (includes 0x00, 0xFF, 0x0F run)
        for (int i = 0; i < 7; i++) begin
            mark();
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, -1, 0);
            check_frame($sformatf("vec%0d", i), 1, vecs[i].data,
                        vecs[i].exp_perr_e, vecs[i].exp_perr_o, vecs[i].exp_ferr);
            check($sformatf("vec%0d_busy", i), {31'd0, busy_e}, 32'd0);
        end

        // short low glitch on idle line: false start, outputs unchanged
        mark();
        rx = 1'b0;
        wait_ticks(2);
        check("glitch_busy_mid", {31'd0, busy_e}, 32'd1);
        wait_ticks(2);
        rx = 1'b1;
        wait_ticks(12);
        check_frame("glitch", 0, 8'h80, 1'b1, 1'b0, 1'b0);
        check("glitch_busy_end", {31'd0, busy_e}, 32'd0);

        // stop bit low, line held low (break), then released
        mark();
        send_frame(8'h55, 1'b0, 1'b0, -1, 0);
        check_frame("break1", 1, 8'h55, 1'b0, 1'b1, 1'b1);
        wait_ticks(164);
        rx = 1'b1;
        wait_ticks(16);
        check_frame("break2", 2, 8'h00, 1'b0, 1'b1, 1'b1);
        check("break_busy", {31'd0, busy_e}, 32'd0);

        // valid frame after break clears frame_err
        mark();
        send_frame(8'hA5, 1'b0, 1'b1, -1, 0);
        check_frame("clear", 1, 8'hA5, 1'b0, 1'b1, 1'b0);

        // reset during data bit 3 of 0xFF aborts the frame
        mark();
        send_bit(1'b0, 0);
        for (int b = 0; b < 3; b++) send_bit(1'b1, 0);
        rx = 1'b1;
        wait_ticks(8);
        check("abort_busy_before", {31'd0, busy_e}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_data",  {24'd0, data_e}, 32'd0);
        check("abort_done",  {31'd0, done_e}, 32'd0);
        check("abort_perr",  {31'd0, perr_e}, 32'd0);
        check("abort_ferr",  {31'd0, ferr_e}, 32'd0);
        check("abort_busy",  {31'd0, busy_e}, 32'd0);
        check("abort_data_odd", {24'd0, data_o}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_ticks(16);
        check("abort_no_done", 32'(cnt_e - base_e), 32'd0);
        mark();
        send_frame(8'h81, 1'b0, 1'b1, -1, 0);
        check_frame("after_rst", 1, 8'h81, 1'b0, 1'b1, 1'b0);

        // one-tick glitch at tick 8 of data bit 2 of 0x0F
        mark();
        send_frame(8'h0F, 1'b0, 1'b1, 2, 8);
        if (VOTING)
            check_frame("dglitch", 1, 8'h0F, 1'b0, 1'b1, 1'b0);
        else
            check_frame("dglitch", 1, 8'h0B, 1'b1, 1'b0, 1'b0);

        wait_ticks(4);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
